// File: rtl/usb_rx_phy.sv
`default_nettype none
// ============================================================================
//  Module   : usb_rx_phy
//  Purpose  : Full-speed USB receive front end: D+/D- lines to a byte stream.
//  Revision : 1.0  initial release
// ============================================================================
module usb_rx_phy #(
    parameter int CLKS_PER_BIT = 4,
    parameter int RESET_CYCLES = 120
) (
    input  logic       clock48,
    input  logic       reset_n,
    input  logic       dp,
    input  logic       dn,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_active,
    output logic       rx_eop,
    output logic       rx_error,
    output logic       bus_reset
);

    localparam int c_ph_w  = $clog2(CLKS_PER_BIT);
    localparam int c_cnt_w = $clog2(RESET_CYCLES + 1);

    localparam logic [1:0] c_ln_se0 = 2'b00;
    localparam logic [1:0] c_ln_k   = 2'b01;
    localparam logic [1:0] c_ln_j   = 2'b10;

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_sync = 3'd1;
    localparam logic [2:0] c_st_data = 3'd2;
    localparam logic [2:0] c_st_eop  = 3'd3;
    localparam logic [2:0] c_st_wait = 3'd4;

    logic               r_dp_meta, r_dp_sync, r_dn_meta, r_dn_sync;
    logic [1:0]         r_line_d, r_prev;
    logic [c_ph_w-1:0]  r_phase;
    logic [c_cnt_w-1:0] r_se0_cnt;
    logic [2:0]         r_state, r_zeros, r_ones, r_bits, r_jcnt;
    logic [1:0]         r_se0_bits;
    logic [7:0]         r_shift, r_byte;
    logic               r_misaligned, r_valid, r_active, r_eop, r_error, r_bus_reset;

    logic [1:0] w_line;
    logic       w_change, w_tick, w_se0, w_j, w_k, w_bit;

    // Synchronizers idle at J so reset release does not look like a line edge
    always_ff @(posedge clock48 or negedge reset_n) begin
        if (!reset_n) begin
            r_dp_meta <= 1'b1;
            r_dp_sync <= 1'b1;
            r_dn_meta <= 1'b0;
            r_dn_sync <= 1'b0;
        end else begin
            r_dp_meta <= dp;
            r_dp_sync <= r_dp_meta;
            r_dn_meta <= dn;
            r_dn_sync <= r_dn_meta;
        end
    end

    always_comb begin
        w_line = c_ln_se0;
        if (r_dp_sync && !r_dn_sync)
            w_line = c_ln_j;
        else if (!r_dp_sync && r_dn_sync)
            w_line = c_ln_k;
    end

    // A tick in the same cycle as an edge would sample the new bit twice
    assign w_change = (w_line != r_line_d);
    assign w_tick   = !w_change && (r_phase == c_ph_w'(CLKS_PER_BIT / 2 - 1));
    assign w_se0    = (w_line == c_ln_se0);
    assign w_j      = (w_line == c_ln_j);
    assign w_k      = (w_line == c_ln_k);
    assign w_bit    = (w_line == r_prev);

    always_ff @(posedge clock48 or negedge reset_n) begin
        if (!reset_n) begin
            r_line_d    <= c_ln_j;
            r_phase     <= '0;
            r_se0_cnt   <= '0;
            r_bus_reset <= 1'b0;
        end else begin
            r_line_d    <= w_line;
            r_phase     <= w_change ? '0 : r_phase + 1'b1;
            if (!w_se0)
                r_se0_cnt <= '0;
            else if (r_se0_cnt != c_cnt_w'(RESET_CYCLES))
                r_se0_cnt <= r_se0_cnt + 1'b1;
            r_bus_reset <= w_se0 && (r_se0_cnt >= c_cnt_w'(RESET_CYCLES - 1));
        end
    end

    always_ff @(posedge clock48 or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= c_st_idle;
            r_prev       <= c_ln_j;
            r_zeros      <= '0;
            r_ones       <= '0;
            r_bits       <= '0;
            r_jcnt       <= '0;
            r_se0_bits   <= '0;
            r_shift      <= '0;
            r_byte       <= '0;
            r_misaligned <= 1'b0;
            r_valid      <= 1'b0;
            r_active     <= 1'b0;
            r_eop        <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_eop   <= 1'b0;
            r_error <= 1'b0;
            if (r_bus_reset) begin
                r_state  <= c_st_idle;
                r_active <= 1'b0;
                if (w_tick)
                    r_prev <= w_line;
            end else if (w_tick) begin
                r_prev <= w_line;
                case (r_state)
                    c_st_idle: begin
                        if (w_k) begin
                            r_state <= c_st_sync;
                            r_zeros <= 3'd1;
                        end
                    end
                    c_st_sync: begin
                        if (w_se0) begin
                            r_state <= c_st_idle;
                        end else if (w_bit) begin
                            if (r_zeros >= 3'd3) begin
                                r_state  <= c_st_data;
                                r_active <= 1'b1;
                                r_bits   <= '0;
                                r_ones   <= '0;
                            end else begin
                                r_state <= c_st_idle;
                            end
                        end else if (r_zeros != 3'd7) begin
                            r_zeros <= r_zeros + 1'b1;
                        end
                    end
                    c_st_data: begin
                        if (w_se0) begin
                            r_state      <= c_st_eop;
                            r_misaligned <= (r_bits != 3'd0);
                            r_se0_bits   <= 2'd1;
                        end else if (r_ones == 3'd6) begin
                            if (w_bit) begin
                                r_error  <= 1'b1;
                                r_active <= 1'b0;
                                r_state  <= c_st_wait;
                                r_jcnt   <= '0;
                            end else begin
                                r_ones <= '0;
                            end
                        end else begin
                            r_shift <= {w_bit, r_shift[7:1]};
                            r_bits  <= r_bits + 1'b1;
                            r_ones  <= w_bit ? r_ones + 1'b1 : 3'd0;
                            if (r_bits == 3'd7) begin
                                r_byte  <= {w_bit, r_shift[7:1]};
                                r_valid <= 1'b1;
                            end
                        end
                    end
                    c_st_eop: begin
                        if (w_se0) begin
                            if (r_se0_bits >= 2'd2) begin
                                r_error  <= 1'b1;
                                r_active <= 1'b0;
                                r_state  <= c_st_wait;
                                r_jcnt   <= '0;
                            end else begin
                                r_se0_bits <= r_se0_bits + 1'b1;
                            end
                        end else if (w_j) begin
                            r_eop    <= 1'b1;
                            r_error  <= r_misaligned;
                            r_active <= 1'b0;
                            r_state  <= c_st_idle;
                        end else begin
                            r_error  <= 1'b1;
                            r_active <= 1'b0;
                            r_state  <= c_st_wait;
                            r_jcnt   <= '0;
                        end
                    end
                    c_st_wait: begin
                        if (w_j) begin
                            if ((r_prev == c_ln_se0) || (r_jcnt == 3'd7))
                                r_state <= c_st_idle;
                            else
                                r_jcnt <= r_jcnt + 1'b1;
                        end else begin
                            r_jcnt <= '0;
                        end
                    end
                    default: r_state <= c_st_idle;
                endcase
            end
        end
    end

    assign rx_byte   = r_byte;
    assign rx_valid  = r_valid;
    assign rx_active = r_active;
    assign rx_eop    = r_eop;
    assign rx_error  = r_error;
    assign bus_reset = r_bus_reset;

endmodule
`default_nettype wire

// File: tb/tb_usb_rx_phy.sv
`default_nettype none
// ============================================================================
//  Module   : tb_usb_rx_phy
//  Purpose  : Directed self-checking bench for usb_rx_phy.
//  Revision : 1.0  initial release
// ============================================================================
module tb_usb_rx_phy;

    localparam logic [1:0] J   = 2'b10;
    localparam logic [1:0] K   = 2'b01;
    localparam logic [1:0] SE0 = 2'b00;

    logic       clock48 = 1'b0;
    logic       reset_n;
    logic       dp, dn;
    logic [7:0] rx_byte;
    logic       rx_valid, rx_active, rx_eop, rx_error, bus_reset;

    int checks = 0;
    int errors = 0;

    int n_valid = 0, n_eop = 0, n_err = 0, n_eop_err = 0, n_val_eop = 0, n_rise = 0;
    logic [7:0] bytes [0:63];
    logic last_act = 1'b0, eop_act = 1'b0, eop_act_prev = 1'b0;

    logic [1:0] lvl;
    int b_v, b_e, b_r, b_rise, b_ee, b_ve;

    usb_rx_phy #(.CLKS_PER_BIT(4), .RESET_CYCLES(120)) dut (
        .clock48   (clock48),
        .reset_n   (reset_n),
        .dp        (dp),
        .dn        (dn),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .rx_active (rx_active),
        .rx_eop    (rx_eop),
        .rx_error  (rx_error),
        .bus_reset (bus_reset)
    );

    always #5 clock48 = ~clock48;

    always @(negedge clock48) begin
        if (rx_valid) begin
            bytes[n_valid % 64] <= rx_byte;
            n_valid <= n_valid + 1;
        end
        if (rx_eop)               n_eop     <= n_eop + 1;
        if (rx_error)             n_err     <= n_err + 1;
        if (rx_eop && rx_error)   n_eop_err <= n_eop_err + 1;
        if (rx_eop && rx_valid)   n_val_eop <= n_val_eop + 1;
        if (rx_active && !last_act) n_rise  <= n_rise + 1;
        if (rx_eop) begin
            eop_act      <= rx_active;
            eop_act_prev <= last_act;
        end
        last_act <= rx_active;
    end

    initial begin
        #1000000;
        $display("FAIL timeout");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_sym(input logic [1:0] s);
        {dp, dn} = s;
        repeat (4) @(negedge clock48);
    endtask

    task automatic send_bit(input logic b);
        if (!b) lvl = (lvl == J) ? K : J;
        send_sym(lvl);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
    endtask

    task automatic send_sync();
        send_byte(8'h80);
    endtask

    task automatic send_eop();
        send_sym(SE0);
        send_sym(SE0);
        lvl = J;
        send_sym(J);
    endtask

    task automatic idle(input int nbits);
        lvl = J;
        repeat (nbits) send_sym(J);
    endtask

    task automatic snap();
        b_v = n_valid; b_e = n_eop; b_r = n_err; b_rise = n_rise;
        b_ee = n_eop_err; b_ve = n_val_eop;
    endtask

    initial begin
        reset_n = 1'b0;
        dp = 1'b1;
        dn = 1'b0;
        lvl = J;
        repeat (3) @(negedge clock48);
        chk("reset_outputs", {19'd0, rx_byte, rx_valid, rx_active, rx_eop, rx_error, bus_reset}, 32'd0);
        reset_n = 1'b1;
        idle(20);

        // Basic two-byte packet
        snap();
        send_sync();
        send_byte(8'hA5);
        send_byte(8'h3C);
        send_eop();
        idle(8);
        chk("pkt_valid_count", n_valid - b_v, 2);
        chk("pkt_byte0", bytes[b_v], 8'hA5);
        chk("pkt_byte1", bytes[b_v + 1], 8'h3C);
        chk("pkt_eop_count", n_eop - b_e, 1);
        chk("pkt_err_count", n_err - b_r, 0);
        chk("pkt_active_rise", n_rise - b_rise, 1);
        chk("pkt_active_in_eop_cycle", eop_act, 1'b0);
        chk("pkt_active_before_eop", eop_act_prev, 1'b1);

        // Stuffed zero after six ones in 0xFF
        snap();
        send_sync();
        repeat (6) send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_byte(8'h01);
        send_eop();
        idle(8);
        chk("stuff_valid_count", n_valid - b_v, 2);
        chk("stuff_byte0", bytes[b_v], 8'hFF);
        chk("stuff_byte1", bytes[b_v + 1], 8'h01);
        chk("stuff_err_count", n_err - b_r, 0);
        chk("stuff_eop_count", n_eop - b_e, 1);

        // Seven ones: stuff violation
        snap();
        send_sync();
        repeat (7) send_bit(1'b1);
        send_eop();
        chk("stufferr_active", rx_active, 1'b0);
        idle(8);
        chk("stufferr_err_count", n_err - b_r, 1);
        chk("stufferr_valid_count", n_valid - b_v, 0);
        chk("stufferr_eop_count", n_eop - b_e, 0);
        snap();
        send_sync();
        send_byte(8'h5A);
        send_eop();
        idle(8);
        chk("recover_valid_count", n_valid - b_v, 1);
        chk("recover_byte", bytes[b_v], 8'h5A);
        chk("recover_eop_count", n_eop - b_e, 1);
        chk("recover_err_count", n_err - b_r, 0);

        // EOP after 12 data bits
        snap();
        send_sync();
        send_byte(8'hA5);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_eop();
        idle(8);
        chk("misalign_valid_count", n_valid - b_v, 1);
        chk("misalign_byte", bytes[b_v], 8'hA5);
        chk("misalign_eop_count", n_eop - b_e, 1);
        chk("misalign_eop_err_same", n_eop_err - b_ee, 1);
        chk("misalign_err_count", n_err - b_r, 1);

        // Bus reset: long SE0
        snap();
        {dp, dn} = SE0;
        repeat (121) @(posedge clock48);
        #1;
        chk("busrst_before_120", bus_reset, 1'b0);
        @(posedge clock48);
        #1;
        chk("busrst_at_120", bus_reset, 1'b1);
        repeat (78) @(posedge clock48);
        @(negedge clock48);
        {dp, dn} = J;
        lvl = J;
        @(posedge clock48);
        @(posedge clock48);
        #1;
        chk("busrst_held_until_sync_j", bus_reset, 1'b1);
        @(posedge clock48);
        #1;
        chk("busrst_release", bus_reset, 1'b0);
        @(negedge clock48);
        idle(10);
        chk("busrst_no_strobes", (n_valid - b_v) + (n_eop - b_e) + (n_err - b_r), 0);

        // Reset in the middle of the second byte
        snap();
        send_sync();
        send_byte(8'hA5);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        chk("midrst_active_before", rx_active, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_outputs_zero", {19'd0, rx_byte, rx_valid, rx_active, rx_eop, rx_error, bus_reset}, 32'd0);
        repeat (3) @(negedge clock48);
        reset_n = 1'b1;
        chk("midrst_first_byte", n_valid - b_v, 1);
        snap();
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_eop();
        idle(10);
        chk("midrst_no_partial", n_valid - b_v, 0);
        snap();
        send_sync();
        send_byte(8'hC3);
        send_eop();
        idle(8);
        chk("after_rst_valid_count", n_valid - b_v, 1);
        chk("after_rst_byte", bytes[b_v], 8'hC3);
        chk("after_rst_eop_count", n_eop - b_e, 1);
        chk("valid_eop_never_together", n_val_eop, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
